// File: rtl/ram64_pkg.sv
// Shared definitions for the RAM64 block and its burst reader.
// The RAM64 bench reuses these defaults and the state type.
package ram64_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } reader_state_e;

endpackage

// File: rtl/ram64.sv
// 64-word RAM: synchronous write when load is high, combinational read of address.
module ram64
  import ram64_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] address,
  input  logic              load,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (load) begin
      mem_q[address] <= in;
    end
  end

  assign out = mem_q[address];

endmodule

// File: rtl/ram64_reader.sv
// Burst reader for RAM64: streams count words from base_addr over a valid/ready
// handshake, one word per two cycles at best, then pulses done.
module ram64_reader
  import ram64_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_load,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              done
);

  reader_state_e     state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remaining_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              done_q;

  // remaining_q counts words not yet fetched; addr_q wraps naturally at 2**ADDR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (count == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              addr_q      <= base_addr;
              remaining_q <= count;
              state_q     <= FETCH;
            end
          end
        end
        FETCH: begin
          data_q      <= mem_out;
          valid_q     <= 1'b1;
          addr_q      <= addr_q + 1'b1;
          remaining_q <= remaining_q - 1'b1;
          state_q     <= SEND;
        end
        SEND: begin
          if (data_ready) begin
            valid_q <= 1'b0;
            if (remaining_q == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= FETCH;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_address = addr_q;
  assign mem_load    = 1'b0;
  assign mem_in      = '0;
  assign data        = data_q;
  assign data_valid  = valid_q;
  assign done        = done_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ram64_reader.sv
// Bench for ram64_reader driving a real RAM64; bursts are checked against a
// word-level model of RAM contents and the two-cycles-per-word timing rule.
module tb_ram64_reader;

  localparam int AW = 6;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count = '0;
  logic [AW-1:0] mem_address;
  logic          mem_load;
  logic [DW-1:0] mem_in;
  logic [DW-1:0] mem_out;
  logic [DW-1:0] data;
  logic          data_valid;
  logic          data_ready = 1'b0;
  logic          busy;
  logic          done;

  logic          preloading = 1'b0;
  logic          tbLoad = 1'b0;
  logic [AW-1:0] tbAddr = '0;
  logic [DW-1:0] tbIn = '0;
  logic [AW-1:0] ramAddr;
  logic          ramLoad;
  logic [DW-1:0] ramIn;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] refMem [64];

  always #5 clk = ~clk;

  assign ramAddr = preloading ? tbAddr : mem_address;
  assign ramLoad = preloading ? tbLoad : mem_load;
  assign ramIn   = preloading ? tbIn   : mem_in;

  ram64 #(.ADDR_W(AW), .DATA_W(DW)) uRam (
    .clk     (clk),
    .address (ramAddr),
    .load    (ramLoad),
    .in      (ramIn),
    .out     (mem_out)
  );

  ram64_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .count       (count),
    .mem_address (mem_address),
    .mem_load    (mem_load),
    .mem_in      (mem_in),
    .mem_out     (mem_out),
    .data        (data),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    int base;
    int cnt;
    int stall;
    int expBusy;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic writeWord(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    preloading = 1'b1;
    tbAddr = 6'(a);
    tbIn = d;
    tbLoad = 1'b1;
    @(negedge clk);
    tbLoad = 1'b0;
    preloading = 1'b0;
    refMem[a] = d;
  endtask

  // One burst: expected words come from refMem, busy length from 2 cycles per
  // word plus stall cycles plus the DONE cycle (expBusy < 0 means derive it).
  task automatic applyStimulus(input int base, input int cnt, input int stall,
                               input int expBusy, input bit randReady, input bit noise);
    logic [DW-1:0] expQ[$];
    logic [DW-1:0] prevData;
    logic [AW-1:0] prevAddr;
    bit            prevHeld;
    bit            finished;
    bit            badConst;
    int            busyCycles;
    int            doneCount;
    int            words;
    int            fetchIdx;
    int            stalls;
    int            firstValid;
    int            stallLeft;
    prevData = '0;
    prevAddr = '0;
    prevHeld = 1'b0;
    finished = 1'b0;
    badConst = 1'b0;
    busyCycles = 0;
    doneCount = 0;
    words = 0;
    fetchIdx = 0;
    stalls = 0;
    firstValid = -1;
    stallLeft = stall;
    for (int i = 0; i < cnt; i++) expQ.push_back(refMem[(base + i) % 64]);

    @(negedge clk);
    start = 1'b1;
    base_addr = 6'(base);
    count = 7'(cnt);
    data_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;

    for (int idx = 0; idx < 1000 && !finished; idx++) begin
      if (!busy) begin
        finished = 1'b1;
        start = 1'b0;
        data_ready = 1'b0;
      end else begin
        if (noise && !done) begin
          start = 1'($urandom);
          base_addr = 6'($urandom);
          count = 7'($urandom_range(0, 64));
        end else begin
          start = 1'b0;
        end
        busyCycles++;
        if (done) doneCount++;
        if (mem_load !== 1'b0 || mem_in !== '0) badConst = 1'b1;
        if (data_valid && firstValid < 0) firstValid = idx;
        if (prevHeld) begin
          checkOutput("held data", 32'(data), 32'(prevData));
          checkOutput("held valid", 32'(data_valid), 32'd1);
          checkOutput("held address", 32'(mem_address), 32'(prevAddr));
        end
        if (!data_valid && !done) begin
          checkOutput("fetch address", 32'(mem_address), 32'((base + fetchIdx) % 64));
          fetchIdx++;
        end
        if (data_valid && stallLeft > 0) begin
          data_ready = 1'b0;
          stallLeft--;
        end else begin
          data_ready = randReady ? 1'($urandom) : 1'b1;
        end
        if (data_valid && !data_ready) stalls++;
        if (data_valid && data_ready) begin
          if (expQ.size() == 0) checkOutput("extra word", 32'(data), 32'hFFFF_FFFF);
          else checkOutput("word", 32'(data), 32'(expQ.pop_front()));
          words++;
        end
        prevHeld = data_valid && !data_ready;
        prevData = data;
        prevAddr = mem_address;
        @(negedge clk);
      end
    end
    start = 1'b0;
    data_ready = 1'b0;

    checks++;
    if (!finished) begin
      errors++;
      $display("[TB] FAIL burst timeout: got busy after 1000 cycles, expected idle");
    end
    if (expBusy < 0) expBusy = (cnt == 0) ? 1 : 2 * cnt + stalls + 1;
    checkOutput("word count", 32'(words), 32'(cnt));
    checkOutput("fetch count", 32'(fetchIdx), 32'(cnt));
    checkOutput("done pulses", 32'(doneCount), 32'd1);
    checkOutput("busy cycles", 32'(busyCycles), 32'(expBusy));
    checkOutput("constant mem outputs", 32'(badConst), 32'd0);
    if (cnt > 0) checkOutput("first valid latency", 32'(firstValid), 32'd1);
    checkOutput("idle after burst", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    int   seenValid;
    bit   hit;
    bit   doneSeen;
    vecs[0] = '{base: 5,  cnt: 3,  stall: 0, expBusy: 7};
    vecs[1] = '{base: 60, cnt: 8,  stall: 2, expBusy: 19};
    vecs[2] = '{base: 0,  cnt: 64, stall: 0, expBusy: 129};
    vecs[3] = '{base: 63, cnt: 1,  stall: 3, expBusy: 6};
    vecs[4] = '{base: 10, cnt: 0,  stall: 0, expBusy: 1};
    vecs[5] = '{base: 33, cnt: 2,  stall: 1, expBusy: 6};

    repeat (2) @(negedge clk);
    checkOutput("reset data", 32'(data), 32'd0);
    checkOutput("reset valid", 32'(data_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset address", 32'(mem_address), 32'd0);
    checkOutput("reset load", 32'(mem_load), 32'd0);
    rst_n = 1'b1;

    writeWord(0, 16'hAAAA);
    writeWord(1, 16'h5555);
    applyStimulus(0, 2, 0, 5, 1'b0, 1'b0);
    applyStimulus(0, 2, 5, 10, 1'b0, 1'b0);

    writeWord(62, 16'h1111);
    writeWord(63, 16'h2222);
    writeWord(0, 16'h3333);
    writeWord(1, 16'h4444);
    applyStimulus(62, 4, 0, 9, 1'b0, 1'b0);

    applyStimulus(7, 0, 0, 1, 1'b0, 1'b0);

    // Abort a burst asynchronously while word 2 is being offered.
    writeWord(0, 16'hAAAA);
    writeWord(1, 16'h5555);
    writeWord(2, 16'h6666);
    writeWord(3, 16'h7777);
    @(negedge clk);
    start = 1'b1;
    base_addr = 6'd0;
    count = 7'd4;
    data_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seenValid = 0;
    hit = 1'b0;
    doneSeen = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      if (done) doneSeen = 1'b1;
      if (data_valid) begin
        seenValid++;
        if (seenValid == 2) hit = 1'b1;
      end
      if (!hit) @(negedge clk);
    end
    data_ready = 1'b0;
    checkOutput("reached word 2", 32'(hit), 32'd1);
    checkOutput("word 2 before reset", 32'(data), 32'h5555);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset data", 32'(data), 32'd0);
    checkOutput("async reset valid", 32'(data_valid), 32'd0);
    checkOutput("async reset busy", 32'(busy), 32'd0);
    checkOutput("async reset address", 32'(mem_address), 32'd0);
    checkOutput("async reset done", 32'(done), 32'd0);
    @(negedge clk);
    if (done) doneSeen = 1'b1;
    checkOutput("no done on abort", 32'(doneSeen), 32'd0);
    rst_n = 1'b1;
    applyStimulus(1, 1, 0, 3, 1'b0, 1'b0);

    for (int a = 0; a < 64; a++) writeWord(a, 16'($urandom));
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].base, vecs[v].cnt, vecs[v].stall, vecs[v].expBusy, 1'b0, 1'b0);
    end

    for (int r = 0; r < 20; r++) begin
      writeWord($urandom_range(0, 63), 16'($urandom));
      applyStimulus($urandom_range(0, 63), $urandom_range(0, 64), $urandom_range(0, 3),
                    -1, 1'b1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
